// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash burst reader.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StData
  } state_e;

  localparam logic [7:0]  OpRead      = 8'h03;
  localparam logic [7:0]  OpFastRead  = 8'h0B;
  localparam int unsigned DummyCycles = 8;

endpackage

// File: rtl/spi_shift_rx.sv
// MSB-first 8-bit receive shifter; byte_done flags the edge that completes a byte,
// with rx_byte already including the bit sampled on that edge.
module spi_shift_rx (
  input  logic       sclk,
  input  logic       rst,
  input  logic       en,
  input  logic       miso,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (!en) begin
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= {shift_q[5:0], miso};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  assign rx_byte   = {shift_q, miso};
  assign byte_done = en && (bit_cnt_q == 3'd7);

endmodule

// File: rtl/spi_flash_burst_reader.sv
// SPI flash burst read master: opcode, address, then len+1 bytes streamed out.
// Define SPI_FAST_READ_EN for fast-read (opcode 0x0B plus 8 dummy edges).
module spi_flash_burst_reader
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LEN_W    = 4,
  parameter logic [7:0]  CMD_READ = 8'h03
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic [7:0]        data_out,
  output logic              data_valid,
  output logic              done,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CntW = $clog2(ADDR_W);
  localparam logic [CntW-1:0] CntAddrTop = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] CntByteTop = CntW'(7);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0]      Opcode      = OpFastRead;
  localparam logic [CntW-1:0] CntDummyTop = CntW'(DummyCycles - 1);
`else
  localparam logic [7:0]      Opcode      = CMD_READ;
`endif

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  bytes_left_q;

  logic       rx_en;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_en = (state_q == StData);

  spi_shift_rx u_rx (
    .sclk      (sclk),
    .rst       (rst),
    .en        (rx_en),
    .miso      (miso),
    .rx_byte   (rx_byte),
    .byte_done (byte_done)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      bytes_left_q <= '0;
      busy         <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      done         <= 1'b0;
      cs           <= 1'b1;
      mosi         <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      done       <= 1'b0;
      if (state_q != StIdle && abort) begin
        cs      <= 1'b1;
        mosi    <= 1'b0;
        busy    <= 1'b0;
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            cs   <= 1'b1;
            mosi <= 1'b0;
            if (start && !abort) begin
              addr_q       <= addr;
              bytes_left_q <= len;
              cs           <= 1'b0;
              busy         <= 1'b1;
              cnt_q        <= CntByteTop;
              state_q      <= StCmd;
            end
          end
          StCmd: begin
            mosi <= Opcode[cnt_q[2:0]];
            if (cnt_q == '0) begin
              cnt_q   <= CntAddrTop;
              state_q <= StAddr;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StAddr: begin
            mosi <= addr_q[cnt_q];
            if (cnt_q == '0) begin
              cnt_q <= CntByteTop;
`ifdef SPI_FAST_READ_EN
              state_q <= StDummy;
              cnt_q   <= CntDummyTop;
`else
              state_q <= StData;
`endif
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`ifdef SPI_FAST_READ_EN
          StDummy: begin
            mosi <= 1'b0;
            if (cnt_q == '0) begin
              cnt_q   <= CntByteTop;
              state_q <= StData;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`endif
          StData: begin
            mosi <= 1'b0;
            if (byte_done) begin
              data_out   <= rx_byte;
              data_valid <= 1'b1;
              // Count down remaining bytes and stop at zero, so len = all-ones never wraps.
              if (bytes_left_q == '0) begin
                cs      <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= StIdle;
              end else begin
                bytes_left_q <= bytes_left_q - 1'b1;
                cnt_q        <= CntByteTop;
              end
            end
          end
          default: begin
            cs      <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Directed bench for spi_flash_burst_reader: edge-accurate flash model on miso,
// checks of the mosi stream, strobes, chip select, abort and async reset.
module tb_spi_flash_burst_reader;

`ifdef SPI_FAST_READ_EN
  localparam int unsigned AW  = 24;
  localparam int          Dum = 8;
  localparam logic [7:0]  Opc = 8'h0B;
  localparam logic [23:0] A0  = 24'h00ABCD;
`else
  localparam int unsigned AW  = 16;
  localparam int          Dum = 0;
  localparam logic [7:0]  Opc = 8'h03;
  localparam logic [15:0] A0  = 16'h1234;
`endif
  localparam int unsigned LW = 4;
  // Edge index (start edge = 1) of the first data bit sample.
  localparam int Ds = 10 + AW + Dum;

  logic          sclk = 1'b0;
  logic          rst, start, abort, miso;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic          busy, data_valid, done, cs, mosi;
  logic [7:0]    data_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sclk = ~sclk;

  spi_flash_burst_reader #(
    .ADDR_W   (AW),
    .LEN_W    (LW),
    .CMD_READ (8'h03)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .start      (start),
    .addr       (addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .done       (done),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Runs one burst of n bytes; bw holds byte j at bw[8*j +: 8]. A nonzero abort_edge or
  // rst_edge cuts the burst short at that edge; poke re-pulses start mid-burst.
  task automatic burst(input logic [AW-1:0] a, input int n, input logic [127:0] bw,
                       input int abort_edge, input int rst_edge, input bit poke);
    int last;
    int bad_cs, bad_mosi, bad_valid, bad_done, bad_busy;
    logic [AW+7:0] got_tx;
    logic [AW+7:0] exp_tx;
    last   = Ds + 8 * n - 1;
    got_tx = '0;
    exp_tx = {Opc, a};
    bad_cs = 0; bad_mosi = 0; bad_valid = 0; bad_done = 0; bad_busy = 0;
    for (int e = 1; e <= last; e++) begin
      int k;
      k     = e - Ds;
      start = (e == 1) || (poke && e == Ds + 3);
      addr  = (e == 1) ? a : ~a;
      len   = (e == 1) ? LW'(n - 1) : '1;
      abort = (e == abort_edge);
      miso  = (k >= 0) ? bw[8 * (k / 8) + 7 - k % 8] : 1'b0;
      tick();
      start = 1'b0;
      if (e >= 2 && e <= 9 + AW) got_tx[9 + AW - e] = mosi;
      else if (mosi !== 1'b0) bad_mosi++;
      if (e == abort_edge) begin
        abort = 1'b0;
        check("abort_cs", 64'(cs), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(data_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        return;
      end
      if (e == rst_edge) begin
        #2 rst = 1'b1;
        #1;
        check("rst_cs", 64'(cs), 64'd1);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        #1 rst = 1'b0;
        return;
      end
      if (k >= 0 && k % 8 == 7) begin
        check("data_valid", 64'(data_valid), 64'd1);
        check("data_out", 64'(data_out), 64'(bw[8 * (k / 8) +: 8]));
      end else if (data_valid !== 1'b0) begin
        bad_valid++;
      end
      if (e < last) begin
        if (cs !== 1'b0) bad_cs++;
        if (busy !== 1'b1) bad_busy++;
        if (done !== 1'b0) bad_done++;
      end
    end
    check("mosi_stream", 64'(got_tx), 64'(exp_tx));
    check("mosi_idle_bits", 64'(bad_mosi), 64'd0);
    check("cs_low_during", 64'(bad_cs), 64'd0);
    check("busy_during", 64'(bad_busy), 64'd0);
    check("early_done", 64'(bad_done), 64'd0);
    check("stray_valid", 64'(bad_valid), 64'd0);
    check("done_pulse", 64'(done), 64'd1);
    check("cs_end", 64'(cs), 64'd1);
    check("busy_end", 64'(busy), 64'd0);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("cs_gap", 64'(cs), 64'd1);
  endtask

  initial begin
    logic [127:0] bw;
    int quiet;
    rst = 1'b1; start = 1'b0; abort = 1'b0; miso = 1'b0; addr = '0; len = '0;
    #12;
    check("reset_cs", 64'(cs), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_mosi", 64'(mosi), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);
    check("reset_strobes", 64'({data_valid, done}), 64'd0);
    rst = 1'b0;
    tick();

    burst(A0, 1, 128'hA5, 0, 0, 1'b0);
    burst(~A0, 4, 128'h44332211, 0, 0, 1'b0);

    // Abort mid-address, then a clean burst.
    burst(A0, 4, 128'h44332211, 20, 0, 1'b0);
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (data_valid !== 1'b0 || done !== 1'b0 || cs !== 1'b1) quiet++;
    end
    check("post_abort_quiet", 64'(quiet), 64'd0);
    burst(A0, 1, 128'h5A, 0, 0, 1'b0);

    // Start re-pulsed mid-burst is ignored.
    burst(A0, 2, 128'hC33C, 0, 0, 1'b1);

    // Abort together with start in idle: nothing begins.
    start = 1'b1; abort = 1'b1; addr = A0; len = '0;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_cs", 64'(cs), 64'd1);
    check("abort_start_busy", 64'(busy), 64'd0);
    tick();
    check("abort_start_idle", 64'({busy, cs}), 64'b01);

    // Maximum length: 16 bytes.
    for (int j = 0; j < 16; j++) bw[8 * j +: 8] = 8'(j * 13 + 7);
    burst(A0, 16, bw, 0, 0, 1'b0);

    // Async reset mid-data after the first byte has landed.
    burst(A0, 2, 128'h0FE1, 0, Ds + 10, 1'b0);
    tick();
    check("post_rst_idle", 64'({busy, cs, data_valid, done}), 64'b0100);
    burst(A0, 1, 128'h96, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_burst_reader.md
Name: spi_flash_burst_reader

Overview:
Parametrised SPI-flash read master. It fetches a burst of consecutive bytes from a serial flash, starting at a programmable address, and streams each byte out with a one-cycle strobe. It sits between the CPU/instruction-fetch logic and the external flash pins. It generalises single-byte fetch with configurable address width, burst length, abort and an optional fast-read mode.

Parameters:
ADDR_W, 16, flash address width in bits (16 or 24), shifted MSB first
LEN_W, 4, width of burst-length input; burst = len+1 bytes (1..2^LEN_W)
CMD_READ, 8'h03, standard read opcode

Ports:
sclk  in  1  SPI/system clock; all logic on posedge
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE
addr  in  ADDR_W  start address, captured with start
len  in  LEN_W  burst length minus one, captured with start
abort  in  1  synchronous abort of the transfer in progress
busy  out  1  transfer in progress
data_out  out  8  last completed byte
data_valid  out  1  one-cycle strobe, data_out new
done  out  1  one-cycle strobe, burst completed normally
cs  out  1  flash chip select, active-low
mosi  out  1  serial data to flash
miso  in  1  serial data from flash

Behaviour:
- Reset values: busy=0, data_out=0, data_valid=0, done=0, cs=1, mosi=0, state IDLE, counters 0. Reset mid-transfer aborts immediately; no done or valid is issued.
- data_valid and done default to 0 every edge.
- States: IDLE, CMD, ADDR, DUMMY (only with the macro), DATA.
- IDLE: cs=1, mosi=0. On start=1 and abort=0: capture addr and len; cs<=0; busy<=1; bit counter<=7; go to CMD.
- CMD: one edge per bit, mosi<=opcode[cnt], MSB first. After bit 0, counter<=ADDR_W-1 and go to ADDR.
- ADDR: mosi<=addr[cnt], MSB first. After bit 0, counter<=7 and go to DATA (or DUMMY).
- DATA: each edge shifts miso into an 8-bit shift register, MSB first. On the 8th bit:
  - data_out<={shift[6:0],miso}; data_valid<=1.
  - If the remaining-byte count is 0: cs<=1, mosi<=0, busy<=0, done<=1, go to IDLE.
  - Otherwise decrement the byte count, counter<=7, stay in DATA.
  - mosi is held 0 throughout DATA.
- Edge counts: a burst of N bytes takes 1+8+ADDR_W+8N edges from the start edge to done (plus dummy cycles, see the optional feature). cs falls on the start edge and rises on the done edge.
- The address is never incremented internally; the flash auto-increments.
- start while busy: ignored, with no effect on the current transfer.
- abort=1 in any non-IDLE state: next edge cs<=1, mosi<=0, busy<=0, state IDLE; no done and no data_valid on that edge.
- abort=1 with start=1 in IDLE: abort wins; no transfer begins.
- len at its maximum (all ones): 2^LEN_W bytes; the byte counter must not wrap early.
- Back-to-back transfers: start may be high on the edge after done. cs is therefore high for at least one edge between bursts.

Optional Feature:
Macro SPI_FAST_READ_EN.
- Defined: opcode is 8'h0B. After ADDR, the DUMMY state holds mosi=0 for exactly 8 edges, then enters DATA. Burst latency becomes 1+8+ADDR_W+8+8N edges.
- Undefined: DUMMY state and opcode logic are absent; opcode is CMD_READ.

Decomposition:
- Shared package spi_pkg: state encoding enum (IDLE, CMD, ADDR, DUMMY, DATA), opcode constants READ=8'h03 and FAST_READ=8'h0B, dummy-cycle count 8.
- One natural sub-module, spi_shift_rx: the 8-bit MSB-first receive shift register with bit counter and byte-complete pulse.
- The FSM, transmit mux and byte counter stay in the top module.

Test Plan:
- ADDR_W=16, addr=16'h1234, len=0, flash returns 8'hA5 -> mosi carries 0x03,0x12,0x34; data_out=8'hA5 with data_valid on edge 33; done on the same edge; cs high for edges 0 and 34+.
- len=3, flash returns 8'h11,8'h22,8'h33,8'h44 -> four data_valid pulses 8 edges apart with those values; a single done on the last one; cs low continuously in between.
- abort asserted on edge 20 (mid-ADDR) -> cs=1 and busy=0 on next edge; no data_valid, no done; a new start then completes normally.
- start pulsed again mid-burst with a different addr -> ignored; original burst's bytes and timing are unchanged.
- rst asserted asynchronously mid-DATA -> cs=1, mosi=0, busy=0, data_out=0 immediately, without waiting for a clock edge.
- With SPI_FAST_READ_EN, ADDR_W=24, addr=24'h00ABCD, len=0 -> mosi 0x0B,0x00,0xAB,0xCD, then 8 zero edges; the byte is captured on edge 49.
